// File: rtl/fmap_mem_arbiter_pkg.sv
// Shared constants and types for the feature-map RAM arbiter:
// requester indices, FSM state encoding and a one-hot decode helper.
package fmap_arb_pkg;

    localparam int unsigned N_REQ   = 4;
    localparam int unsigned REQ_CAM = 0;
    localparam int unsigned REQ_FET = 1;
    localparam int unsigned REQ_WB  = 2;
    localparam int unsigned REQ_AVE = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic logic [1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = i[1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/fmap_mem_arbiter_rr_pick.sv
// Combinational 4-way round-robin picker: first set request at or above
// the pointer (mod 4) wins; any_o flags that at least one request is set.
module rr_pick
    import fmap_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [1:0]       ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic             any_o
);

    logic [1:0] idx;

    always_comb begin
        gnt_o = '0;
        idx   = '0;
        any_o = |req_i;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = ptr_i + i[1:0];
            if (gnt_o == '0 && req_i[idx]) gnt_o[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fmap_mem_arbiter.sv
// Round-robin, burst-locked arbiter sharing the single-port feature-map RAM.
// Optional grant watchdog enabled by defining FMAP_ARB_WATCHDOG_EN.
module fmap_mem_arbiter
    import fmap_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned WD_LIMIT = 255
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ-1:0]        i_valid,
    input  logic [N_REQ-1:0]        i_last,
    input  logic [N_REQ-1:0]        i_we,
    input  logic [N_REQ*ADDR_W-1:0] i_addr,
    input  logic [N_REQ*DATA_W-1:0] i_wdata,
    output logic [N_REQ-1:0]        o_gnt,
    output logic                    o_mem_en,
    output logic                    o_mem_we,
    output logic [ADDR_W-1:0]       o_mem_addr,
    output logic [DATA_W-1:0]       o_mem_wdata,
    input  logic [DATA_W-1:0]       i_mem_rdata,
    output logic [DATA_W-1:0]       o_rdata,
    output logic [N_REQ-1:0]        o_rvalid,
    output logic                    o_wd_err
);

    arb_state_e                    state_q, state_d;
    logic [N_REQ-1:0]              gnt_q, gnt_d;
    logic [1:0]                    ptr_q, ptr_d;
    logic [RD_LAT-1:0][N_REQ-1:0]  rtag_q;

    logic [1:0]        gnt_idx, pick_ptr;
    logic [N_REQ-1:0]  pick_gnt, rd_push;
    logic              pick_any, valid_k, last_k, req_k, we_k;
    logic              release_w, wd_fire;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;

    assign gnt_idx = onehot_to_idx(gnt_q);
    assign valid_k = |(gnt_q & i_valid);
    assign last_k  = |(gnt_q & i_last);
    assign req_k   = |(gnt_q & i_req);
    assign we_k    = |(gnt_q & i_we);

    // gnt_q is zero in IDLE, so the muxed address/data read 0 without a grant
    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (gnt_q[k]) begin
                addr_mux  = addr_mux  | i_addr[k*ADDR_W +: ADDR_W];
                wdata_mux = wdata_mux | i_wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    assign o_gnt       = gnt_q;
    assign o_mem_en    = valid_k;
    assign o_mem_we    = valid_k & we_k;
    assign o_mem_addr  = addr_mux;
    assign o_mem_wdata = wdata_mux;

    assign release_w = (state_q == GRANT) && ((valid_k && last_k) || !req_k || wd_fire);
    // On release the picker already searches from k+1 so the next grant lands with no bubble
    assign pick_ptr  = (state_q == GRANT) ? gnt_idx + 2'd1 : ptr_q;

    rr_pick u_pick (
        .req_i (i_req),
        .ptr_i (pick_ptr),
        .gnt_o (pick_gnt),
        .any_o (pick_any)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_gnt;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (release_w) begin
                    ptr_d = gnt_idx + 2'd1;
                    if (pick_any) begin
                        gnt_d = pick_gnt;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign rd_push = (o_mem_en && !o_mem_we) ? gnt_q : '0;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rtag_q <= '0;
        end else begin
            rtag_q[0] <= rd_push;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                rtag_q[i] <= rtag_q[i-1];
            end
        end
    end

    assign o_rvalid = rtag_q[RD_LAT-1];
    assign o_rdata  = (|o_rvalid) ? i_mem_rdata : '0;

`ifdef FMAP_ARB_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WD_LIMIT + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            wd_err_q;

    assign wd_fire  = (state_q == GRANT) && !valid_k && (wd_cnt_q == WD_W'(WD_LIMIT - 1));
    assign wd_cnt_d = ((state_q == GRANT) && !valid_k && !release_w) ? wd_cnt_q + 1'b1 : '0;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            wd_err_q <= wd_err_q | wd_fire;
        end
    end

    assign o_wd_err = wd_err_q;
`else
    assign wd_fire  = 1'b0;
    assign o_wd_err = 1'b0;
`endif

endmodule
